// File: rtl/cut_window_ctrl.sv
// Cut-window rectangle controller: latches move/resize requests and commits all
// four coordinates together during vertical blank, once every FRAME_DIV frames.
module cut_window_ctrl #(
    parameter int H_MAX     = 640,
    parameter int V_MAX     = 480,
    parameter int INIT_X1   = 280,
    parameter int INIT_Y1   = 200,
    parameter int INIT_W    = 80,
    parameter int INIT_H    = 80,
    parameter int STEP      = 4,
    parameter int FRAME_DIV = 2,
    parameter int MIN_SIZE  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       en,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_grow,
    input  logic       btn_shrink,
    output logic [9:0] x1,
    output logic [9:0] y1,
    output logic [9:0] x2,
    output logic [9:0] y2,
    output logic       updated
);

    localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FRAME_DIV - 1);
    localparam logic signed [11:0] STEP_S   = 12'(STEP);
    localparam logic signed [11:0] MIN_S    = 12'(MIN_SIZE);
    localparam logic signed [11:0] X_LIM    = 12'(H_MAX - 1);
    localparam logic signed [11:0] Y_LIM    = 12'(V_MAX - 1);

    // Request bit positions inside req_q
    localparam int R_UP = 5, R_DOWN = 4, R_LEFT = 3, R_RIGHT = 2, R_GROW = 1, R_SHRINK = 0;

    typedef enum logic {IDLE, APPLY} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       req_q, req_d;
    logic [9:0]       x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
    logic             updated_q, updated_d;

    logic signed [11:0] dx, dy, dsize;
    logic [19:0]        x_new, y_new;

    // Move one axis (position preserved width), then resize from the moved edge.
    function automatic logic [19:0] step_axis(input logic [9:0] lo, input logic [9:0] hi,
                                              input logic signed [11:0] d_move,
                                              input logic signed [11:0] d_size,
                                              input logic signed [11:0] lim);
        logic signed [11:0] p, w, nw, far;
        w = signed'({2'b00, hi}) - signed'({2'b00, lo});
        p = signed'({2'b00, lo}) + d_move;
        if (p < 12'sd0)
            p = 12'sd0;
        if (p + w > lim)
            p = lim - w;
        nw = w + d_size;
        if (nw < MIN_S)
            nw = MIN_S;
        if (nw > lim - p)
            nw = lim - p;
        far = p + nw;
        return {p[9:0], far[9:0]};
    endfunction

    always_comb begin
        dx    = (req_q[R_RIGHT] ? STEP_S : 12'sd0) - (req_q[R_LEFT]   ? STEP_S : 12'sd0);
        dy    = (req_q[R_DOWN]  ? STEP_S : 12'sd0) - (req_q[R_UP]     ? STEP_S : 12'sd0);
        dsize = (req_q[R_GROW]  ? STEP_S : 12'sd0) - (req_q[R_SHRINK] ? STEP_S : 12'sd0);
        x_new = step_axis(x1_q, x2_q, dx, dsize, X_LIM);
        y_new = step_axis(y1_q, y2_q, dy, dsize, Y_LIM);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        x1_d      = x1_q;
        y1_d      = y1_q;
        x2_d      = x2_q;
        y2_d      = y2_q;
        updated_d = 1'b0;

        if (en) begin
            // Presses in the APPLY cycle survive the clear and carry to the next period
            req_d = ((state_q == APPLY) ? 6'd0 : req_q)
                  | {btn_up, btn_down, btn_left, btn_right, btn_grow, btn_shrink};
            if (frame_tick)
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
            req_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (en && frame_tick && cnt_q == CNT_LAST)
                    state_d = APPLY;
            end
            APPLY: begin
                state_d = IDLE;
                if (en) begin
                    {x1_d, x2_d} = x_new;
                    {y1_d, y2_d} = y_new;
                    updated_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            x1_q      <= 10'(INIT_X1);
            y1_q      <= 10'(INIT_Y1);
            x2_q      <= 10'(INIT_X1 + INIT_W);
            y2_q      <= 10'(INIT_Y1 + INIT_H);
            updated_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            x1_q      <= x1_d;
            y1_q      <= y1_d;
            x2_q      <= x2_d;
            y2_q      <= y2_d;
            updated_q <= updated_d;
        end
    end

    assign x1      = x1_q;
    assign y1      = y1_q;
    assign x2      = x2_q;
    assign y2      = y2_q;
    assign updated = updated_q;

endmodule

// File: tb/tb_cut_window_ctrl.sv
// Directed bench for cut_window_ctrl with hand-computed coordinate expectations.
module tb_cut_window_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       en = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       btn_grow = 1'b0, btn_shrink = 1'b0;
    logic [9:0] x1, y1, x2, y2;
    logic       updated;

    int n_checks = 0;
    int n_fail   = 0;
    int upd_cnt  = 0;

    cut_window_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .en         (en),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_grow   (btn_grow),
        .btn_shrink (btn_shrink),
        .x1         (x1),
        .y1         (y1),
        .x2         (x2),
        .y2         (y2),
        .updated    (updated)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (updated === 1'b1) upd_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        idle(1);
        frame_tick = 1'b0;
    endtask

    // Two ticks then one cycle: returns when the committed values are visible
    task automatic period();
        tick();
        idle(2);
        tick();
        idle(1);
    endtask

    task automatic do_reset();
        {btn_up, btn_down, btn_left, btn_right, btn_grow, btn_shrink} = 6'b0;
        en  = 1'b1;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic chk_coords(input string tag, input int ex1, input int ey1,
                              input int ex2, input int ey2);
        chk({tag, ".x1"}, 32'(x1), 32'(ex1));
        chk({tag, ".y1"}, 32'(y1), 32'(ey1));
        chk({tag, ".x2"}, 32'(x2), 32'(ex2));
        chk({tag, ".y2"}, 32'(y2), 32'(ey2));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        @(posedge clk);
        #1;
        do_reset();
        chk_coords("reset", 280, 200, 360, 280);
        chk("reset.updated", 32'(updated), 0);

        // One-cycle press, update lands on second tick, two cycles later
        btn_right = 1'b1;
        idle(1);
        btn_right = 1'b0;
        tick();
        idle(2);
        chk("tick1.x1", 32'(x1), 284 - 4);
        chk("tick1.updated", 32'(updated), 0);
        tick();
        chk("apply_cycle.x1", 32'(x1), 280);
        chk("apply_cycle.updated", 32'(updated), 0);
        idle(1);
        chk_coords("move_right", 284, 200, 364, 280);
        chk("move_right.updated", 32'(updated), 1);
        idle(1);
        chk("move_right.pulse_end", 32'(updated), 0);

        // Walk left to the edge, then one extra clamped update
        btn_left = 1'b1;
        repeat (71) period();
        chk("left71.x1", 32'(x1), 0);
        chk("left71.x2", 32'(x2), 80);
        period();
        chk("left_clamp.x1", 32'(x1), 0);
        chk("left_clamp.x2", 32'(x2), 80);
        chk("left_clamp.updated", 32'(updated), 1);
        btn_left = 1'b0;

        btn_right = 1'b1;
        repeat (145) period();
        chk("right_clamp.x1", 32'(x1), 559);
        chk("right_clamp.x2", 32'(x2), 639);
        chk("right_clamp.updated", 32'(updated), 1);
        btn_right = 1'b0;

        // Shrink down to minimum size
        do_reset();
        btn_shrink = 1'b1;
        repeat (20) period();
        chk_coords("shrink_min", 280, 200, 288, 208);
        btn_shrink = 1'b0;

        // Move a minimum-size window to x1=600, then grow against the right edge
        do_reset();
        btn_right  = 1'b1;
        btn_shrink = 1'b1;
        repeat (79) period();
        btn_right  = 1'b0;
        btn_shrink = 1'b0;
        period();
        chk_coords("at600", 600, 200, 608, 208);
        btn_grow = 1'b1;
        repeat (10) period();
        chk_coords("grow_clamp", 600, 200, 639, 248);
        btn_grow = 1'b0;

        // Opposing requests cancel but still commit
        do_reset();
        {btn_left, btn_right, btn_grow, btn_shrink} = 4'b1111;
        period();
        chk_coords("cancel", 280, 200, 360, 280);
        chk("cancel.updated", 32'(updated), 1);

        // en low across two ticks: no commit, latch dropped
        do_reset();
        btn_down = 1'b1;
        idle(1);
        btn_down = 1'b0;
        en = 1'b0;
        base = upd_cnt;
        tick();
        idle(2);
        tick();
        idle(2);
        chk("en_low.pulses", 32'(upd_cnt - base), 0);
        chk("en_low.y1", 32'(y1), 200);
        en = 1'b1;
        period();
        chk("en_back.updated", 32'(updated), 1);
        chk("en_back.y1", 32'(y1), 200);

        // Reset during the APPLY cycle aborts the commit and empties the latch
        do_reset();
        btn_right = 1'b1;
        idle(1);
        btn_right = 1'b0;
        period();
        chk("pre_abort.x1", 32'(x1), 284);
        btn_down = 1'b1;
        idle(1);
        btn_down = 1'b0;
        tick();
        idle(2);
        tick();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk_coords("abort", 280, 200, 360, 280);
        chk("abort.updated", 32'(updated), 0);
        period();
        chk_coords("after_abort", 280, 200, 360, 280);
        chk("after_abort.updated", 32'(updated), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cut_window_ctrl.md
Name: cut_window_ctrl

Overview:
Frame-synchronous controller that owns the rectangle coordinates (x1, y1, x2, y2) feeding the layer-cut stage of the VGA pixel pipeline. It accepts user move and resize requests, latches them between frames, and applies them once every FRAME_DIV frames during vertical blank. The four coordinates change atomically, so the cut window never tears mid-frame. All results are clamped to the visible area and to a minimum size.

Parameters:
H_MAX, 640, visible width in pixels; x coordinates are limited to 0..H_MAX-1
V_MAX, 480, visible height in lines; y coordinates are limited to 0..V_MAX-1
INIT_X1, 280, reset value of x1
INIT_Y1, 200, reset value of y1
INIT_W, 80, reset width; x2 = x1 + W
INIT_H, 80, reset height; y2 = y1 + H
STEP, 4, pixels moved or resized per applied update
FRAME_DIV, 2, number of frame_tick pulses per applied update (>=1)
MIN_SIZE, 8, minimum width and minimum height

Ports:
clk  in  1  system clock (pixel-domain clock)
rst  in  1  synchronous reset, active-high
frame_tick  in  1  one-cycle pulse at start of vertical blank
en  in  1  update enable
btn_up  in  1  move up request (level or pulse)
btn_down  in  1  move down request
btn_left  in  1  move left request
btn_right  in  1  move right request
btn_grow  in  1  grow request: x2/y2 +STEP
btn_shrink  in  1  shrink request: x2/y2 -STEP
x1  out  10  left edge (inclusive)
y1  out  10  top edge (inclusive)
x2  out  10  right edge (inclusive)
y2  out  10  bottom edge (inclusive)
updated  out  1  one-cycle pulse when the coordinates were just committed

Behaviour:
- Reset values: x1=INIT_X1, y1=INIT_Y1, x2=INIT_X1+INIT_W, y2=INIT_Y1+INIT_H, updated=0, request latches=0, frame_cnt=0, state=IDLE. Reset mid-APPLY aborts with no commit.
- Request latch, one sticky bit per button: set on any cycle the button is high; cleared in the APPLY cycle. A set and a clear on the same cycle leave the bit set, so a press during APPLY carries to the next period.
- frame_cnt counts every frame_tick while en=1. If en=0: frame_cnt is held at 0, latches are cleared, and coordinates are held.
- IDLE -> APPLY: on a frame_tick with en=1 and frame_cnt==FRAME_DIV-1. frame_cnt wraps to 0 on that tick; otherwise it increments.
- APPLY -> IDLE: always, after exactly one cycle. Coordinates and updated=1 are registered on the APPLY->IDLE edge, i.e. visible 2 cycles after the qualifying tick. updated is high for exactly that one cycle, including when the coordinates do not change.
- A frame_tick arriving in the APPLY cycle is counted normally.
- Arithmetic: 12-bit signed intermediates; w = x2-x1 and h = y2-y1 are taken from the current outputs.
- Move: dx = STEP*(right-left), dy = STEP*(down-up). Opposing requests cancel.
  - Apply x1+dx.
  - If x1<0: x1=0.
  - If x1+w > H_MAX-1: x1 = H_MAX-1-w.
  - Width is always preserved by a move. y is handled identically with V_MAX.
- Resize, applied after the move using the moved x1/y1:
  - w' = w + STEP*(grow-shrink); grow and shrink together cancel.
  - Clamp w' to [MIN_SIZE, H_MAX-1-x1].
  - x2 = x1 + w'. Same for h' and y2 with V_MAX.
- Invariant at all times: x1 < x2 <= H_MAX-1 and y1 < y2 <= V_MAX-1.

Test Plan:
- Reset: rst high for 2 clk, then low -> x1=280, y1=200, x2=360, y2=280, updated=0.
- btn_right held 1 clk, then frame_tick #1 -> no change. frame_tick #2 -> 2 clk later x1=284, x2=364, updated=1 for 1 clk. Coordinates are stable at all other times.
- btn_left held for 71 update periods -> x1 decrements by 4 to 0, x2=80. The 71st update leaves x1=0, x2=80 with updated still pulsing. Symmetric right-edge case ends at x2=639, x1=559.
- btn_shrink held for 20 periods from reset -> w steps 80, 76, ... down to 8, then stays x2=288, and likewise y2=208. Grow at x1=600 clamps x2 to 639.
- btn_left+btn_right and btn_grow+btn_shrink asserted together -> coordinates unchanged and updated pulses. en=0 during two ticks -> no updated pulse, latches cleared.
- rst asserted in the APPLY cycle with btn_down latched -> outputs return to reset values, no updated pulse, the next period starts with an empty latch.
